// File: rtl/midi_msg_parser_if.sv
// Byte stream in from the MIDI UART receiver, assembled channel messages and real-time bytes out.
interface midi_msg_parser_if;
  logic       rx_byte_valid;
  logic [7:0] rx_byte;
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [3:0] channel;
  logic [6:0] data1;
  logic [6:0] data2;
  logic       rt_valid;
  logic [7:0] rt_byte;

  modport master (
    output rx_byte_valid, rx_byte,
    input  msg_valid, msg_type, channel, data1, data2, rt_valid, rt_byte
  );

  modport slave (
    input  rx_byte_valid, rx_byte,
    output msg_valid, msg_type, channel, data1, data2, rt_valid, rt_byte
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message assembler with running status; one-cycle latency, never stalls.
// Define MIDI_PARSER_RT_EN to forward real-time bytes F8..FF on the rt outputs.
module midi_msg_parser #(
  parameter int OMNI    = 1,
  parameter int CHANNEL = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  midi_msg_parser_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_D1, ST_D2, ST_SYSEX} state_t;

  state_t     r_state;
  logic [2:0] r_run_type;
  logic [3:0] r_run_chan;
  logic [6:0] r_data1;

  logic       r_msg_valid;
  logic [2:0] r_msg_type;
  logic [3:0] r_channel;
  logic [6:0] r_out_d1;
  logic [6:0] r_out_d2;

  logic       w_vld;
  logic [7:0] w_byte;
  logic       w_is_rt;
  logic       w_is_sys;
  logic       w_two_data;
  logic       w_accept;
  logic       w_emit;
  logic [6:0] w_emit_d1;
  logic [6:0] w_emit_d2;
  logic [2:0] w_emit_type;

  assign w_vld      = bus.rx_byte_valid;
  assign w_byte     = bus.rx_byte;
  assign w_is_rt    = (w_byte[7:3] == 5'b11111);
  assign w_is_sys   = (w_byte[7:4] == 4'hF);
  // Program change (Cx) and channel pressure (Dx) carry a single data byte
  assign w_two_data = (r_run_type != 3'd4) && (r_run_type != 3'd5);
  assign w_accept   = (OMNI != 0) || (r_run_chan == 4'(CHANNEL));

  assign w_emit      = w_vld && !w_byte[7] &&
                       (((r_state == ST_D1) && !w_two_data) || (r_state == ST_D2));
  assign w_emit_d1   = (r_state == ST_D2) ? r_data1 : w_byte[6:0];
  assign w_emit_d2   = (r_state == ST_D2) ? w_byte[6:0] : 7'd0;
  assign w_emit_type = ((r_run_type == 3'd1) && (w_emit_d2 == 7'd0)) ? 3'd0 : r_run_type;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_run_type  <= 3'd0;
      r_run_chan  <= 4'd0;
      r_data1     <= 7'd0;
      r_msg_valid <= 1'b0;
      r_msg_type  <= 3'd0;
      r_channel   <= 4'd0;
      r_out_d1    <= 7'd0;
      r_out_d2    <= 7'd0;
    end else begin
      r_msg_valid <= 1'b0;
      if (w_emit) begin
        r_msg_valid <= w_accept;
        if (w_accept) begin
          r_msg_type <= w_emit_type;
          r_channel  <= r_run_chan;
          r_out_d1   <= w_emit_d1;
          r_out_d2   <= w_emit_d2;
        end
      end

      if (w_vld && w_byte[7] && !w_is_rt) begin
        if (!w_is_sys) begin
          r_run_type <= w_byte[6:4];
          r_run_chan <= w_byte[3:0];
          r_state    <= ST_D1;
        end else begin
          r_run_type <= 3'd0;
          r_run_chan <= 4'd0;
          r_state    <= (w_byte == 8'hF0) ? ST_SYSEX : ST_IDLE;
        end
      end else if (w_vld && !w_byte[7]) begin
        case (r_state)
          ST_D1: begin
            r_data1 <= w_byte[6:0];
            if (w_two_data) r_state <= ST_D2;
          end
          ST_D2:   r_state <= ST_D1;
          default: ;
        endcase
      end
    end
  end

  assign bus.msg_valid = r_msg_valid;
  assign bus.msg_type  = r_msg_type;
  assign bus.channel   = r_channel;
  assign bus.data1     = r_out_d1;
  assign bus.data2     = r_out_d2;

`ifdef MIDI_PARSER_RT_EN
  logic       r_rt_valid;
  logic [7:0] r_rt_byte;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rt_valid <= 1'b0;
      r_rt_byte  <= 8'd0;
    end else begin
      r_rt_valid <= w_vld && w_is_rt;
      if (w_vld && w_is_rt) r_rt_byte <= w_byte;
    end
  end

  assign bus.rt_valid = r_rt_valid;
  assign bus.rt_byte  = r_rt_byte;
`else
  assign bus.rt_valid = 1'b0;
  assign bus.rt_byte  = 8'd0;
`endif

endmodule
